bin_frame_packer: RTL and testbench

BIN_FRAME_PACKER -- requirements
Module: bin_frame_packer

---
 rtl/fpga_mip_pkg.sv | 24 ++
 rtl/pix_shift8.sv | 27 ++
 rtl/bin_frame_packer.sv | 123 ++++++++++++
 tb/tb_bin_frame_packer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga_mip_pkg.sv
// Shared definitions for the binary-image packing path.
// Holds the default frame geometry, derived frame sizes and the packer FSM encoding.
// Frame-size helpers let each instance derive its own sizes from its parameters.
package fpga_mip_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;
  localparam int FRAME_WORDS  = FRAME_PIXELS / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PACK = 1'b1
  } pack_state_t;

  function automatic int frame_pixels(input int h, input int v);
    return h * v;
  endfunction

  function automatic int frame_words(input int h, input int v);
    return (h * v) / 8;
  endfunction

endpackage

// File: rtl/pix_shift8.sv
// Purpose: MSB-first serial-to-parallel shifter for binary pixels.
// Latency: next_byte is combinational; it covers the 7 stored pixels plus din.
// Backpressure: none; the register shifts only when shift_en is high.
// Ports: clk/rst, shift_en (accept din), din (pixel), next_byte (byte that din completes).
module pix_shift8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       din,
  output logic [7:0] next_byte
);

  // Only seven bits are stored. The eighth pixel of a group is merged in
  // combinationally, so the byte is ready on the same edge that accepts it.
  logic [6:0] sr;

  assign next_byte = {sr, din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= {sr[5:0], din};
    end
  end

endmodule

// File: rtl/bin_frame_packer.sv
// Purpose: packs a binary pixel stream into 8-pixel words (MSB first) for the image RAM.
// Latency: a word is written 1 cycle after the pixel that completes it; frame_done pulses with the final write.
// Backpressure: none. pix_valid low holds all state; stray pixels between frames set the sticky err_overrun.
// Ports: pix_valid/pix_sof/pix_data in, err_clr in; wr_addr/wr_data/wren out; busy/frame_done/err_short/err_overrun out.
module bin_frame_packer
  import fpga_mip_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic              pix_data,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wren,
  output logic              busy,
  output logic              frame_done,
  output logic              err_short,
  output logic              err_overrun
);

  localparam int FRM_PIX = frame_pixels(H_ACTIVE, V_ACTIVE);
  localparam int CNT_W   = $clog2(FRM_PIX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRM_PIX - 1);

  pack_state_t      state_q, state_d;
  logic [CNT_W-1:0] pix_cnt;     // pixels accepted so far in the current frame
  logic             frame_seen;  // a frame has completed since reset
  logic             accept_sof, accept_pix, stray_pix;
  logic             word_full, last_pix, shift_en;
  logic [7:0]       next_byte;

  always_comb begin
    state_d    = state_q;
    accept_sof = 1'b0;
    accept_pix = 1'b0;
    stray_pix  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pix_valid) begin
          if (pix_sof) begin
            accept_sof = 1'b1;
            state_d    = ST_PACK;
          end else begin
            stray_pix = 1'b1;
          end
        end
      end
      ST_PACK: begin
        if (pix_valid) begin
          if (pix_sof) begin
            // A restart keeps the FSM in PACK; the partial word is simply never written.
            accept_sof = 1'b1;
          end else begin
            accept_pix = 1'b1;
            if (pix_cnt == LAST_CNT) state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // pix_cnt counts pixels before the current one, so its low 3 bits are the
  // position within the group and pix_cnt>>3 is the index of the word being filled.
  assign word_full = accept_pix && (pix_cnt[2:0] == 3'd7);
  assign last_pix  = accept_pix && (pix_cnt == LAST_CNT);
  assign shift_en  = accept_sof | accept_pix;
  assign busy      = (state_q == ST_PACK);

  pix_shift8 u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (pix_data),
    .next_byte(next_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pix_cnt     <= '0;
      frame_seen  <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wren        <= 1'b0;
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_q    <= state_d;
      wren       <= word_full;
      frame_done <= last_pix;
      err_short  <= accept_sof && (state_q == ST_PACK);

      if (accept_sof) begin
        pix_cnt <= CNT_W'(1);
      end else if (accept_pix) begin
        pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
      end

      if (word_full) begin
        wr_data <= next_byte;
        wr_addr <= ADDR_W'(pix_cnt >> 3);
      end

      if (last_pix) frame_seen <= 1'b1;

      // Setting wins over clearing when both happen in the same cycle.
      if (stray_pix && frame_seen) begin
        err_overrun <= 1'b1;
      end else if (err_clr) begin
        err_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bin_frame_packer.sv
module tb_bin_frame_packer;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int FP = H * V;
  localparam int FW = FP / 8;
  localparam int AW = 16;

  logic          clk, rst;
  logic          pix_valid, pix_sof, pix_data, err_clr;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wren, busy, frame_done, err_short, err_overrun;

  bin_frame_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .err_clr(err_clr), .wr_addr(wr_addr), .wr_data(wr_data),
    .wren(wren), .busy(busy), .frame_done(frame_done), .err_short(err_short),
    .err_overrun(err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame is a list of accepted pixels; every 8th pixel
  // yields one expected word whose address is its position in the list.
  bit          m_in_frame, m_seen, m_ovr;
  bit          m_q[$];
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  bit          m_wren, m_done, m_short;

  task automatic model_reset();
    m_in_frame = 0; m_seen = 0; m_ovr = 0;
    m_q.delete();
    m_addr = '0; m_data = '0;
    m_wren = 0; m_done = 0; m_short = 0;
  endtask

  task automatic cycle(input bit v, input bit s, input bit d, input bit c);
    bit set_ovr;
    int base;
    pix_valid = v; pix_sof = s; pix_data = d; err_clr = c;
    @(posedge clk);
    m_wren = 0; m_done = 0; m_short = 0; set_ovr = 0;
    if (v) begin
      if (s) begin
        if (m_in_frame) m_short = 1;
        m_q.delete();
        m_q.push_back(d);
        m_in_frame = 1;
      end else if (m_in_frame) begin
        m_q.push_back(d);
        if (m_q.size() % 8 == 0) begin
          m_wren = 1;
          m_addr = 16'(m_q.size() / 8 - 1);
          base = m_q.size() - 8;
          for (int i = 0; i < 8; i++) m_data[7-i] = m_q[base+i];
          if (m_q.size() == FP) begin
            m_done = 1;
            m_in_frame = 0;
            m_seen = 1;
          end
        end
      end else if (m_seen) begin
        set_ovr = 1;
      end
    end
    if (set_ovr) m_ovr = 1;
    else if (c) m_ovr = 0;
    @(negedge clk);
    chk("wren", wren, m_wren);
    chk("frame_done", frame_done, m_done);
    chk("err_short", err_short, m_short);
    chk("err_overrun", err_overrun, m_ovr);
    chk("busy", busy, m_in_frame);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
    if (wren) n_wr++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wren"}, wren, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_short"}, err_short, 0);
    chk({tag, "_err_overrun"}, err_overrun, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
  endtask

  typedef struct {
    bit         v, s, d;
    bit         e_wren;
    logic [7:0] e_data;
    logic [15:0] e_addr;
    bit         e_short;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [7:0] gb;
    int w0;

    pix_valid = 0; pix_sof = 0; pix_data = 0; err_clr = 0; rst = 0;

    // Short-frame table: 12 ones, then a restart whose first 8 pixels are 0000_0001.
    for (int i = 0; i < 20; i++) begin
      tbl[i].v = 1;
      tbl[i].s = (i == 0) || (i == 12);
      tbl[i].d = (i < 12) || (i == 19);
      tbl[i].e_wren  = (i == 7) || (i == 19);
      tbl[i].e_data  = (i == 7) ? 8'hFF : 8'h01;
      tbl[i].e_addr  = 16'd0;
      tbl[i].e_short = (i == 12);
    end

    // Reset state
    @(negedge clk);
    rst = 1;
    #1;
    check_all_zero("reset");
    model_reset();
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].d, 0);
      chk("tbl_wren", wren, tbl[i].e_wren);
      chk("tbl_err_short", err_short, tbl[i].e_short);
      if (tbl[i].e_wren) begin
        chk("tbl_wr_data", wr_data, tbl[i].e_data);
        chk("tbl_wr_addr", wr_addr, tbl[i].e_addr);
      end
    end

    // Pixels with random idle gaps still form one word.
    gb = 8'b1100_1011;
    w0 = n_wr;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat ($urandom_range(0, 5)) cycle(0, 0, 1'($urandom), 0);
      cycle(1, i == 0, gb[7-i], 0);
    end
    chk("gap_wren", wren, 1);
    chk("gap_wr_data", wr_data, 8'hCB);
    chk("gap_wr_addr", wr_addr, 0);
    chk("gap_write_count", n_wr - w0, 1);

    // Full frame of alternating 1,0 pixels.
    w0 = n_wr;
    for (int i = 0; i < FP; i++) cycle(1, i == 0, (i % 2) == 0, 0);
    chk("full_write_count", n_wr - w0, FW);
    chk("full_last_addr", wr_addr, FW - 1);
    chk("full_last_data", wr_data, 8'hAA);
    chk("full_done", frame_done, 1);
    cycle(0, 0, 0, 0);
    chk("full_idle_busy", busy, 0);

    // Stray pixels after a completed frame.
    w0 = n_wr;
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0);
    chk("ovr_no_write", n_wr - w0, 0);
    chk("ovr_set", err_overrun, 1);
    cycle(0, 0, 0, 1);
    chk("ovr_clr", err_overrun, 0);
    cycle(1, 0, 0, 1);
    chk("ovr_set_wins", err_overrun, 1);

    // Reset after 100 pixels of a frame.
    for (int i = 0; i < 100; i++) cycle(1, i == 0, (i % 2) == 0, 0);
    #2;
    rst = 1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst = 0;
    w0 = n_wr;
    for (int i = 0; i < 10; i++) cycle(1, 0, 1'($urandom), 0);
    chk("midrst_no_write", n_wr - w0, 0);
    chk("midrst_no_ovr", err_overrun, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
            1'($urandom), $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
